// File: rtl/bus_pkg.sv
// Shared encodings for the processor datapath: bus source select and
// default datapath dimensions used by both the control FSM and the datapath.
package bus_pkg;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_IR  = 2'd1,
    SRC_G   = 2'd2,
    SRC_DIN = 2'd3
  } bus_src_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

endpackage

// File: rtl/bus_src_mux.sv
// Combinational 4-way source select feeding the shared processor bus.
module bus_src_mux
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] reg_val,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y
);

  // Pick the source named by sel.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves y unassigned (no latch).
    y = reg_val;
    case (bus_src_e'(sel))
      SRC_REG: y = reg_val;
      SRC_IR:  y = ir;
      SRC_G:   y = g;
      SRC_DIN: y = din;
      default: y = reg_val;
    endcase
  end

endmodule

// File: rtl/bus_regfile.sv
// General-purpose register bank with integrated bus driver. The top register
// is the program counter with its own increment port; the bus keeps its last
// driven value when no source is enabled.
module bus_regfile
  import bus_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREGS = DEF_NREGS,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       sel_src,
  input  logic [IDXW-1:0]  rd_idx,
  input  logic             bus_oe,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic             pc_inc,
  input  logic [IDXW-1:0]  dbg_idx,
  output logic [WIDTH-1:0] buswires,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int PC_IDX = NREGS - 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] bus_hold;
  logic [WIDTH-1:0] src_val;

  bus_src_mux #(.WIDTH(WIDTH)) u_src_mux (
    .sel     (sel_src),
    .reg_val (regs[rd_idx]),
    .ir      (ir),
    .g       (g),
    .din     (din),
    .y       (src_val)
  );

  // Bus value: forced to zero in reset, driven source when enabled, else held value.
  always_comb begin
    buswires = bus_hold;
    if (reset) begin
      buswires = '0;
    end else if (bus_oe) begin
      buswires = src_val;
    end
  end

  // Remember the last driven bus value so an idle bus keeps it.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_hold <= '0;
    end else if (bus_oe) begin
      bus_hold <= buswires;
    end
  end

  // Register array: bus capture and PC increment; a write to the PC beats the increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the whole array is reset on purpose; every register must read 0 after reset.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (pc_inc) begin
        regs[PC_IDX] <= regs[PC_IDX] + WIDTH'(1);
      end
      // NOTE: the later non-blocking assignment to the same element wins, giving the write priority.
      if (wr_en) begin
        regs[wr_idx] <= buswires;
      end
    end
  end

  assign pc       = regs[PC_IDX];
  assign dbg_data = regs[dbg_idx];

endmodule

// File: tb/tb_bus_regfile.sv
// Self-checking bench for bus_regfile. Two instances run side by side on the
// same stimulus: the default 16-bit/8-register bank and an 8-bit/4-register
// bank. A behavioural model of both is compared against every cycle.
module tb_bus_regfile;
  import bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel_src = '0;
  logic [2:0]  rd_idx = '0;
  logic        bus_oe = 1'b0;
  logic [15:0] ir = '0;
  logic [15:0] g = '0;
  logic [15:0] din = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic        pc_inc = 1'b0;
  logic [2:0]  dbg_idx = '0;

  logic [15:0] bus_a, pc_a, dbg_a;
  logic [7:0]  bus_b, pc_b, dbg_b;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model state: index 0 = 16x8 bank, index 1 = 8x4 bank (values kept masked).
  logic [15:0] mreg [2][8];
  logic [15:0] mhold [2];

  always #5 clock = ~clock;

  bus_regfile #(.WIDTH(16), .NREGS(8)) dut_a (
    .clock    (clock),
    .reset    (reset),
    .sel_src  (sel_src),
    .rd_idx   (rd_idx),
    .bus_oe   (bus_oe),
    .ir       (ir),
    .g        (g),
    .din      (din),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .pc_inc   (pc_inc),
    .dbg_idx  (dbg_idx),
    .buswires (bus_a),
    .pc       (pc_a),
    .dbg_data (dbg_a)
  );

  bus_regfile #(.WIDTH(8), .NREGS(4)) dut_b (
    .clock    (clock),
    .reset    (reset),
    .sel_src  (sel_src),
    .rd_idx   (rd_idx[1:0]),
    .bus_oe   (bus_oe),
    .ir       (ir[7:0]),
    .g        (g[7:0]),
    .din      (din[7:0]),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx[1:0]),
    .pc_inc   (pc_inc),
    .dbg_idx  (dbg_idx[1:0]),
    .buswires (bus_b),
    .pc       (pc_b),
    .dbg_data (dbg_b)
  );

  function automatic logic [15:0] mask_of(int k);
    return (k == 0) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic int nr_of(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int ix(int k, logic [2:0] i);
    return int'(i) % nr_of(k);
  endfunction

  // What the bus must show right now for bank k.
  function automatic logic [15:0] exp_bus(int k);
    if (reset) return 16'h0000;
    if (!bus_oe) return mhold[k];
    case (sel_src)
      2'd0:    return mreg[k][ix(k, rd_idx)];
      2'd1:    return ir & mask_of(k);
      2'd2:    return g & mask_of(k);
      default: return din & mask_of(k);
    endcase
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge (inputs are stable then).
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic [15:0] b;
      int          top;
      int          w;
      b   = exp_bus(k);
      top = nr_of(k) - 1;
      w   = ix(k, wr_idx);
      if (reset) begin
        for (int j = 0; j < 8; j++) mreg[k][j] = 16'h0000;
        mhold[k] = 16'h0000;
      end else begin
        if (bus_oe) mhold[k] = b;
        if (pc_inc && !(wr_en && w == top))
          mreg[k][top] = (mreg[k][top] + 16'h0001) & mask_of(k);
        if (wr_en) mreg[k][w] = b;
      end
    end
  end

  // Every-cycle comparison away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("bus16", bus_a, exp_bus(0));
      check("pc16",  pc_a,  mreg[0][7]);
      check("dbg16", dbg_a, mreg[0][dbg_idx]);
      check("bus8",  {8'h00, bus_b}, exp_bus(1));
      check("pc8",   {8'h00, pc_b},  mreg[1][3]);
      check("dbg8",  {8'h00, dbg_b}, mreg[1][dbg_idx[1:0]]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_oe = 1'b0;
    wr_en  = 1'b0;
    pc_inc = 1'b0;
  endtask

  task automatic load(logic [2:0] idx, logic [15:0] val);
    sel_src = SRC_DIN;
    din     = val;
    bus_oe  = 1'b1;
    wr_en   = 1'b1;
    wr_idx  = idx;
    pc_inc  = 1'b0;
    cyc();
    idle();
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) mreg[k][j] = 16'h0000;
      mhold[k] = 16'h0000;
    end
    cyc();
    cmp_en = 1'b1;
    reset  = 1'b0;

    // Reset clears preloaded state; writes and increments in the reset cycle are lost.
    for (int i = 0; i < 8; i++) load(3'(i), 16'hA001 + 16'(i));
    reset   = 1'b1;
    sel_src = SRC_DIN;
    din     = 16'hFFFF;
    wr_en   = 1'b1;
    wr_idx  = 3'd7;
    pc_inc  = 1'b1;
    @(negedge clock);
    check("rst_bus", bus_a, 16'h0000);
    cyc();
    reset = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      dbg_idx = 3'(i);
      @(negedge clock);
      check("rst_dbg16", dbg_a, 16'h0000);
      check("rst_dbg8", {8'h00, dbg_b}, 16'h0000);
      cyc();
    end
    @(negedge clock);
    check("rst_pc", pc_a, 16'h0000);
    check("rst_hold_bus", bus_a, 16'h0000);
    cyc();

    // DIN load into reg3, then read it back onto the bus.
    load(3'd3, 16'h1234);
    sel_src = SRC_REG;
    rd_idx  = 3'd3;
    bus_oe  = 1'b1;
    dbg_idx = 3'd3;
    @(negedge clock);
    check("din_dbg", dbg_a, 16'h1234);
    check("din_bus", bus_a, 16'h1234);
    check("din_pc8", {8'h00, pc_b}, 16'h0034);
    cyc();
    idle();

    // Move and hold: bus keeps BEEF while disabled; held value is what gets written.
    load(3'd2, 16'hBEEF);
    load(3'd5, 16'h5555);
    sel_src = SRC_REG;
    rd_idx  = 3'd2;
    bus_oe  = 1'b1;
    cyc();
    bus_oe  = 1'b0;
    sel_src = SRC_DIN;
    din     = 16'h0001;
    rd_idx  = 3'd5;
    wr_en   = 1'b1;
    wr_idx  = 3'd4;
    @(negedge clock);
    check("hold_bus", bus_a, 16'hBEEF);
    cyc();
    sel_src = SRC_REG;
    wr_idx  = 3'd5;
    @(negedge clock);
    check("hold_bus2", bus_a, 16'hBEEF);
    cyc();
    idle();
    dbg_idx = 3'd4;
    @(negedge clock);
    check("hold_wr4", dbg_a, 16'hBEEF);
    cyc();
    dbg_idx = 3'd5;
    @(negedge clock);
    check("hold_self", dbg_a, 16'hBEEF);
    cyc();

    // PC wrap (16'hFFFF and 8'hFF both roll to zero), then two more increments.
    load(3'd7, 16'hFFFF);
    pc_inc = 1'b1;
    cyc();
    pc_inc = 1'b0;
    @(negedge clock);
    check("wrap_pc16", pc_a, 16'h0000);
    check("wrap_pc8", {8'h00, pc_b}, 16'h0000);
    pc_inc = 1'b1;
    cyc();
    cyc();
    pc_inc = 1'b0;
    @(negedge clock);
    check("inc2_pc16", pc_a, 16'h0002);
    check("inc2_pc8", {8'h00, pc_b}, 16'h0002);
    cyc();

    // Write versus increment on the PC: write wins.
    load(3'd7, 16'h0010);
    sel_src = SRC_DIN;
    din     = 16'h0100;
    bus_oe  = 1'b1;
    wr_en   = 1'b1;
    wr_idx  = 3'd7;
    pc_inc  = 1'b1;
    cyc();
    idle();
    @(negedge clock);
    check("wvi_pc16", pc_a, 16'h0100);
    check("wvi_pc8", {8'h00, pc_b}, 16'h0000);
    cyc();

    // Write to another register with increment: both happen.
    load(3'd7, 16'h0010);
    sel_src = SRC_DIN;
    din     = 16'h0100;
    bus_oe  = 1'b1;
    wr_en   = 1'b1;
    wr_idx  = 3'd1;
    pc_inc  = 1'b1;
    cyc();
    idle();
    dbg_idx = 3'd1;
    @(negedge clock);
    check("both_pc16", pc_a, 16'h0011);
    check("both_r1", dbg_a, 16'h0100);
    check("both_pc8", {8'h00, pc_b}, 16'h0011);
    check("both_r1_8", {8'h00, dbg_b}, 16'h0000);
    cyc();

    // Randomized traffic with occasional mid-sequence resets.
    repeat (3000) begin
      reset   = ($urandom_range(0, 39) == 0);
      sel_src = 2'($urandom_range(0, 3));
      rd_idx  = 3'($urandom_range(0, 7));
      bus_oe  = 1'($urandom_range(0, 1));
      ir      = 16'($urandom);
      g       = 16'($urandom);
      din     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      wr_en   = 1'($urandom_range(0, 1));
      wr_idx  = 3'($urandom_range(0, 7));
      pc_inc  = 1'($urandom_range(0, 1));
      dbg_idx = 3'($urandom_range(0, 7));
      cyc();
    end

    reset = 1'b0;
    idle();
    cyc();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
